axis_dual_input_op: RTL and testbench
=====================================

Name: axis_dual_input_op

Overview:
- Two-input, one-output AXI-Stream operator with a single registered output stage.
- OPERATION selects one of three functions:
  - combiner: interleaves fixed-length bursts from the two ports.
  - filter: drops or keeps port-0 beats according to a port-1 flag.
  - shifter: shifts port-0 data by the amount on port 1.
- Sits between stream producers and consumers in the compression datapath.

Parameters:
- OPERATION, 0, function select: 0 = combiner, 1 = filter, 2 = shifter; other values are illegal (elaboration error).
- DATA_WIDTH, 39, width of input_0_data and output_data.
- SIDE_WIDTH, 6, width of input_1_data.
- FROM_PORT_ZERO, 16, combiner: beats taken from port 0 per round; must be >= 1.
- FROM_PORT_ONE, 7, combiner: beats taken from port 1 per round; must be >= 1.
- ELIMINATE_ON_UP, 1, filter: 1 drops a beat when flag bit0 = 1; 0 drops it when flag bit0 = 0.
- LEFT, 1, shifter: 1 = shift left, 0 = shift right.
- ARITHMETIC, 0, shifter: for right shifts, 1 = sign-fill, 0 = zero-fill.

Ports:
- clk, in, 1, clock; all logic on rising edge.
- rst, in, 1, synchronous active-high reset.
- input_0_valid / input_0_ready, in/out, 1, port-0 handshake.
- input_0_data, in, DATA_WIDTH, port-0 payload.
- input_1_valid / input_1_ready, in/out, 1, port-1 handshake.
- input_1_data, in, SIDE_WIDTH, port-1 payload: flag or shift amount.
- output_valid, out, 1, output holds a beat.
- output_data, out, DATA_WIDTH, output payload.
- output_ready, in, 1, downstream accepts.

Behaviour:
- Reset (synchronous, rst = 1 at a rising edge):
  - output_valid = 0, output_data = 0.
  - Combiner phase = port 0, beat counter = 0.
  - input_*_ready = 0 while rst is high.
- Transfers: a transfer happens on any port when valid & ready are both high at a rising edge.
- Output register:
  - space = !output_valid | output_ready.
  - When loaded: output_valid = 1, data = result.
  - When output_ready = 1 and not reloaded: output_valid = 0.
  - output_data holds while output_valid & !output_ready.
  - Latency 1 cycle; full throughput of 1 beat/cycle when output_ready stays high.
- Ready signals never depend on output_valid combinationally from the same beat (no loops); they may depend on input valids.
- Combiner (OPERATION = 0):
  - input_0_ready = space & phase0; input_1_ready = space & !phase0.
  - The other port is always not ready.
  - Result = selected port's data; port-1 data is zero-extended to DATA_WIDTH (truncated if SIDE_WIDTH > DATA_WIDTH).
  - Counter increments per accepted beat.
  - After FROM_PORT_ZERO beats on port 0: switch to port 1, counter = 0.
  - After FROM_PORT_ONE beats on port 1: switch back to port 0.
  - An idle selected port stalls; the other port is never served out of turn.
- Filter (OPERATION = 1):
  - Joined handshake: input_0_ready = space & input_1_valid; input_1_ready = space & input_0_valid. Both inputs are consumed in the same cycle.
  - Drop condition: input_1_data[0] == ELIMINATE_ON_UP. On drop, the output register is not loaded (output_valid falls if drained). Upper flag bits are ignored.
  - Otherwise the output register is loaded with input_0_data.
  - A drop still requires space.
- Shifter (OPERATION = 2):
  - Same joined handshake as the filter.
  - Shift amount s = unsigned input_1_data.
  - LEFT = 1: data << s, zero-filled.
  - LEFT = 0, ARITHMETIC = 0: logical right shift.
  - LEFT = 0, ARITHMETIC = 1: arithmetic right shift (MSB replicated).
  - s >= DATA_WIDTH: result is all zeros, or all copies of the MSB for arithmetic right.
- Reset mid-operation: any held output beat and the combiner round position are discarded; the next round starts at port 0.

Test Plan:
- Combiner, defaults, both generators streaming counting values 0,1,2…, drain always ready:
  - Output = port-0 values 0..15, then port-1 values 0..6 zero-extended, then port-0 values 16..31.
  - One beat per cycle; first output 1 cycle after first accept.
- Combiner with drain stalled for 5 cycles mid-burst:
  - output_data held stable; input readies low while output_valid & !output_ready.
  - No beats lost or duplicated; burst counts still 16/7.
- Filter, ELIMINATE_ON_UP = 1, data 0..7, flags 0,1,0,1,…:
  - Output = 0,2,4,6; all 8 pairs consumed.
  - With ELIMINATE_ON_UP = 0: output = 1,3,5,7.
- Filter with port 1 idle while port 0 is valid:
  - input_0_ready stays 0; no output.
- Shifter, LEFT = 1, data 0x3, shift 4:
  - Output 0x30.
  - Shift 39 → output 0.
  - LEFT = 0, ARITHMETIC = 1, data MSB set, shift 38 → all ones.
- rst asserted for 1 cycle while output_valid = 1 mid-round:
  - Next cycle output_valid = 0.
  - Combiner restarts with 16 port-0 beats.

Source files
------------

// File: rtl/axis_dual_input_op.sv
// axis_dual_input_op: two-input, one-output AXI-Stream operator.
// The OPERATION parameter selects the function:
//   0 = combiner: alternating fixed-length bursts from port 0 then port 1
//   1 = filter:   drop or keep port-0 beats according to a port-1 flag bit
//   2 = shifter:  shift port-0 data by the amount carried on port 1
// All three functions feed one registered output stage (latency of one cycle,
// one beat per cycle while output_ready stays high).
module axis_dual_input_op #(
    parameter int OPERATION       = 0,
    parameter int DATA_WIDTH      = 39,
    parameter int SIDE_WIDTH      = 6,
    parameter int FROM_PORT_ZERO  = 16,
    parameter int FROM_PORT_ONE   = 7,
    parameter int ELIMINATE_ON_UP = 1,
    parameter int LEFT            = 1,
    parameter int ARITHMETIC      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  input_0_valid,
    output logic                  input_0_ready,
    input  logic [DATA_WIDTH-1:0] input_0_data,
    input  logic                  input_1_valid,
    output logic                  input_1_ready,
    input  logic [SIDE_WIDTH-1:0] input_1_data,
    output logic                  output_valid,
    output logic [DATA_WIDTH-1:0] output_data,
    input  logic                  output_ready
);

    // The beat counter only has to reach the longer of the two bursts minus one.
    localparam int MAX_BURST = (FROM_PORT_ZERO > FROM_PORT_ONE) ? FROM_PORT_ZERO : FROM_PORT_ONE;
    localparam int CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    // Port-1 data is widened to this before being cut back to DATA_WIDTH,
    // which handles both zero-extension and truncation.
    localparam int EXT_W     = (DATA_WIDTH > SIDE_WIDTH) ? DATA_WIDTH : SIDE_WIDTH;
    // Flag level on input_1_data[0] that discards a beat in filter mode.
    localparam logic DROP_LEVEL = (ELIMINATE_ON_UP != 0) ? 1'b1 : 1'b0;

    generate
        if ((OPERATION < 0) || (OPERATION > 2)) begin : g_bad_operation
            $error("axis_dual_input_op: OPERATION must be 0, 1 or 2");
        end
        if ((FROM_PORT_ZERO < 1) || (FROM_PORT_ONE < 1)) begin : g_bad_burst
            $error("axis_dual_input_op: FROM_PORT_ZERO and FROM_PORT_ONE must be at least 1");
        end
    endgenerate

    // Zero-extend (or truncate) a port-1 word to the output width.
    function automatic logic [DATA_WIDTH-1:0] zero_extend_side(input logic [SIDE_WIDTH-1:0] side);
        logic [EXT_W-1:0] wide;
        wide = EXT_W'(side);
        return wide[DATA_WIDTH-1:0];
    endfunction

    // Shift port-0 data; amounts at or beyond the word width saturate to the fill value.
    function automatic logic [DATA_WIDTH-1:0] shift_data(input logic [DATA_WIDTH-1:0] data,
                                                          input logic [SIDE_WIDTH-1:0] amount);
        logic [DATA_WIDTH-1:0] fill;
        logic [DATA_WIDTH-1:0] result;
        if ((ARITHMETIC != 0) && (LEFT == 0) && data[DATA_WIDTH-1]) begin
            fill = {DATA_WIDTH{1'b1}};
        end else begin
            fill = {DATA_WIDTH{1'b0}};
        end
        if (32'(amount) >= 32'(DATA_WIDTH)) begin
            result = fill;
        end else if (LEFT != 0) begin
            result = data << amount;
        end else if (ARITHMETIC != 0) begin
            result = DATA_WIDTH'($signed(data) >>> amount);
        end else begin
            result = data >> amount;
        end
        return result;
    endfunction

    logic                  phase0_r;        // 1 while the combiner serves port 0
    logic [CNT_W-1:0]      beat_cnt_r;      // beats accepted in the current combiner burst
    logic                  space_s;
    logic                  joined_fire_s;
    logic                  load_s;
    logic [DATA_WIDTH-1:0] result_s;
    logic [DATA_WIDTH-1:0] side_ext_s;
    logic [DATA_WIDTH-1:0] shifted_s;

    // Handshakes and output-register load decision for the selected operation
    always_comb begin
        space_s       = ~output_valid | output_ready;
        joined_fire_s = space_s & input_0_valid & input_1_valid & ~rst;
        side_ext_s    = zero_extend_side(input_1_data);
        shifted_s     = shift_data(input_0_data, input_1_data);
        input_0_ready = 1'b0;
        input_1_ready = 1'b0;
        load_s        = 1'b0;
        result_s      = {DATA_WIDTH{1'b0}};
        case (OPERATION)
            32'sd0: begin
                // Only the port whose turn it is may be ready; the other waits.
                input_0_ready = space_s & phase0_r & ~rst;
                input_1_ready = space_s & ~phase0_r & ~rst;
                if (phase0_r) begin
                    load_s   = input_0_valid & space_s & ~rst;
                    result_s = input_0_data;
                end else begin
                    load_s   = input_1_valid & space_s & ~rst;
                    result_s = side_ext_s;
                end
            end
            32'sd1: begin
                // Joined handshake: a pair is consumed even when the beat is dropped.
                input_0_ready = space_s & input_1_valid & ~rst;
                input_1_ready = space_s & input_0_valid & ~rst;
                load_s        = joined_fire_s & (input_1_data[0] != DROP_LEVEL);
                result_s      = input_0_data;
            end
            32'sd2: begin
                input_0_ready = space_s & input_1_valid & ~rst;
                input_1_ready = space_s & input_0_valid & ~rst;
                load_s        = joined_fire_s;
                result_s      = shifted_s;
            end
            default: begin
                input_0_ready = 1'b0;
                input_1_ready = 1'b0;
                load_s        = 1'b0;
                result_s      = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    // Combiner round position: which port is served and how far into its burst
    always_ff @(posedge clk) begin
        if (rst) begin
            phase0_r   <= 1'b1;
            beat_cnt_r <= {CNT_W{1'b0}};
        end else if ((OPERATION == 32'sd0) && load_s) begin
            if (phase0_r) begin
                if (beat_cnt_r == CNT_W'(FROM_PORT_ZERO - 1)) begin
                    phase0_r   <= 1'b0;
                    beat_cnt_r <= {CNT_W{1'b0}};
                end else begin
                    beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                end
            end else begin
                if (beat_cnt_r == CNT_W'(FROM_PORT_ONE - 1)) begin
                    phase0_r   <= 1'b1;
                    beat_cnt_r <= {CNT_W{1'b0}};
                end else begin
                    beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                end
            end
        end else begin
            phase0_r   <= phase0_r;
            beat_cnt_r <= beat_cnt_r;
        end
    end

    // Output register: load a new result, drain on output_ready, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            output_valid <= 1'b0;
            output_data  <= {DATA_WIDTH{1'b0}};
        end else if (load_s) begin
            output_valid <= 1'b1;
            output_data  <= result_s;
        end else if (output_ready) begin
            output_valid <= 1'b0;
            output_data  <= output_data;
        end else begin
            output_valid <= output_valid;
            output_data  <= output_data;
        end
    end

endmodule

// File: tb/tb_axis_dual_input_op.sv
// Directed self-checking bench for axis_dual_input_op: one combiner, two
// filters (drop on flag 1 / drop on flag 0) and three shifters (left,
// arithmetic right, logical right) share clock and reset.
module tb_axis_dual_input_op;

    localparam int DW = 39;
    localparam int SW = 6;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   p0 = 0;      // next value from the port-0 producer of the combiner
    int   p1 = 0;      // next value from the port-1 producer of the combiner

    always #5 clk = ~clk;

    // Combiner signals
    logic          c_in0_valid, c_in0_ready, c_in1_valid, c_in1_ready, c_out_valid, c_out_ready;
    logic [DW-1:0] c_in0_data, c_out_data;
    logic [SW-1:0] c_in1_data;
    // Filter signals (inputs shared by both filters)
    logic          f_in0_valid, f_in1_valid, f_out_ready;
    logic [DW-1:0] f_in0_data;
    logic [SW-1:0] f_in1_data;
    logic          f1_in0_ready, f1_in1_ready, f1_out_valid;
    logic          f0_in0_ready, f0_in1_ready, f0_out_valid;
    logic [DW-1:0] f1_out_data, f0_out_data;
    // Shifter signals (inputs shared by all shifters)
    logic          s_in0_valid, s_in1_valid, s_out_ready;
    logic [DW-1:0] s_in0_data;
    logic [SW-1:0] s_in1_data;
    logic          sl_in0_ready, sl_in1_ready, sl_out_valid;
    logic          sa_in0_ready, sa_in1_ready, sa_out_valid;
    logic          sr_in0_ready, sr_in1_ready, sr_out_valid;
    logic [DW-1:0] sl_out_data, sa_out_data, sr_out_data;

    axis_dual_input_op #(.OPERATION(0)) u_comb (
        .clk(clk), .rst(rst),
        .input_0_valid(c_in0_valid), .input_0_ready(c_in0_ready), .input_0_data(c_in0_data),
        .input_1_valid(c_in1_valid), .input_1_ready(c_in1_ready), .input_1_data(c_in1_data),
        .output_valid(c_out_valid), .output_data(c_out_data), .output_ready(c_out_ready));

    axis_dual_input_op #(.OPERATION(1), .ELIMINATE_ON_UP(1)) u_filt1 (
        .clk(clk), .rst(rst),
        .input_0_valid(f_in0_valid), .input_0_ready(f1_in0_ready), .input_0_data(f_in0_data),
        .input_1_valid(f_in1_valid), .input_1_ready(f1_in1_ready), .input_1_data(f_in1_data),
        .output_valid(f1_out_valid), .output_data(f1_out_data), .output_ready(f_out_ready));

    axis_dual_input_op #(.OPERATION(1), .ELIMINATE_ON_UP(0)) u_filt0 (
        .clk(clk), .rst(rst),
        .input_0_valid(f_in0_valid), .input_0_ready(f0_in0_ready), .input_0_data(f_in0_data),
        .input_1_valid(f_in1_valid), .input_1_ready(f0_in1_ready), .input_1_data(f_in1_data),
        .output_valid(f0_out_valid), .output_data(f0_out_data), .output_ready(f_out_ready));

    axis_dual_input_op #(.OPERATION(2), .LEFT(1), .ARITHMETIC(0)) u_shl (
        .clk(clk), .rst(rst),
        .input_0_valid(s_in0_valid), .input_0_ready(sl_in0_ready), .input_0_data(s_in0_data),
        .input_1_valid(s_in1_valid), .input_1_ready(sl_in1_ready), .input_1_data(s_in1_data),
        .output_valid(sl_out_valid), .output_data(sl_out_data), .output_ready(s_out_ready));

    axis_dual_input_op #(.OPERATION(2), .LEFT(0), .ARITHMETIC(1)) u_sra (
        .clk(clk), .rst(rst),
        .input_0_valid(s_in0_valid), .input_0_ready(sa_in0_ready), .input_0_data(s_in0_data),
        .input_1_valid(s_in1_valid), .input_1_ready(sa_in1_ready), .input_1_data(s_in1_data),
        .output_valid(sa_out_valid), .output_data(sa_out_data), .output_ready(s_out_ready));

    axis_dual_input_op #(.OPERATION(2), .LEFT(0), .ARITHMETIC(0)) u_srl (
        .clk(clk), .rst(rst),
        .input_0_valid(s_in0_valid), .input_0_ready(sr_in0_ready), .input_0_data(s_in0_data),
        .input_1_valid(s_in1_valid), .input_1_ready(sr_in1_ready), .input_1_data(s_in1_data),
        .output_valid(sr_out_valid), .output_data(sr_out_data), .output_ready(s_out_ready));

    task automatic test_reset();
        c_in0_valid = 1'b1; c_in1_valid = 1'b1; c_out_ready = 1'b1;
        f_in0_valid = 1'b1; f_in1_valid = 1'b1; f_out_ready = 1'b1;
        s_in0_valid = 1'b1; s_in1_valid = 1'b1; s_out_ready = 1'b1;
        c_in0_data = '0; c_in1_data = '0; f_in0_data = '0; f_in1_data = '0;
        s_in0_data = '0; s_in1_data = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({c_in0_ready, c_in1_ready, f1_in0_ready, f1_in1_ready, sl_in0_ready, sa_in1_ready} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_ready: readies=%b expected 000000",
                     {c_in0_ready, c_in1_ready, f1_in0_ready, f1_in1_ready, sl_in0_ready, sa_in1_ready});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({c_out_valid, f1_out_valid, f0_out_valid, sl_out_valid, sa_out_valid, sr_out_valid} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 000000",
                     {c_out_valid, f1_out_valid, f0_out_valid, sl_out_valid, sa_out_valid, sr_out_valid});
        end
        checks++;
        if ((c_out_data | f1_out_data | sl_out_data | sa_out_data) !== {DW{1'b0}}) begin
            errors++;
            $display("FAIL reset_data: got %0h %0h %0h %0h expected 0",
                     c_out_data, f1_out_data, sl_out_data, sa_out_data);
        end
        c_in0_valid = 1'b0; c_in1_valid = 1'b0;
        f_in0_valid = 1'b0; f_in1_valid = 1'b0;
        s_in0_valid = 1'b0; s_in1_valid = 1'b0;
    endtask

    // Reset the combiner, then stream both producers for a number of cycles,
    // optionally stalling the drain; outputs are compared with a round model
    // that starts from the producers' current values.
    task automatic comb_run(input int cycles, input int stall_start, input int stall_len);
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] held;
        int            oi;
        int            e0;
        int            e1;
        bit            acc0;
        bit            acc1;
        bit            stall;
        held = '0;
        c_in0_valid = 1'b1; c_in1_valid = 1'b1; c_out_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ((c_in0_ready !== 1'b0) || (c_in1_ready !== 1'b0)) begin
            errors++;
            $display("FAIL comb_rst_ready: in0_ready=%b in1_ready=%b expected 0 0", c_in0_ready, c_in1_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        e0 = p0;
        e1 = p1;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 16; k++) begin exp_q.push_back(DW'(e0)); e0++; end
            for (int k = 0; k < 7; k++)  begin exp_q.push_back(DW'(e1)); e1++; end
        end
        oi = 0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            c_in0_data  = DW'(p0);
            c_in1_data  = SW'(p1);
            stall       = (cyc >= stall_start) && (cyc < stall_start + stall_len);
            c_out_ready = !stall;
            @(negedge clk);
            if (cyc == 0) begin
                checks++;
                if (c_out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL comb_after_reset_valid: got %b expected 0", c_out_valid);
                end
            end
            if (cyc == 1) begin
                checks++;
                if (c_out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL comb_latency: output_valid=%b expected 1 one cycle after first accept", c_out_valid);
                end
            end
            checks++;
            if ((c_in0_ready & c_in1_ready) !== 1'b0) begin
                errors++;
                $display("FAIL comb_both_ready: in0_ready=%b in1_ready=%b expected at most one", c_in0_ready, c_in1_ready);
            end
            if (c_out_valid && !c_out_ready) begin
                if (cyc == stall_start) begin
                    held = c_out_data;
                end else begin
                    checks++;
                    if (c_out_data !== held) begin
                        errors++;
                        $display("FAIL comb_hold: data=%0h expected %0h", c_out_data, held);
                    end
                end
                checks++;
                if ((c_in0_ready !== 1'b0) || (c_in1_ready !== 1'b0)) begin
                    errors++;
                    $display("FAIL comb_stall_ready: in0_ready=%b in1_ready=%b expected 0 0", c_in0_ready, c_in1_ready);
                end
            end
            if (c_out_valid && c_out_ready) begin
                checks++;
                if ((oi >= exp_q.size()) || (c_out_data !== exp_q[oi])) begin
                    errors++;
                    $display("FAIL comb_data[%0d]: got %0h expected %0h", oi, c_out_data,
                             (oi < exp_q.size()) ? exp_q[oi] : {DW{1'b1}});
                end
                oi++;
            end
            acc0 = c_in0_valid && c_in0_ready;
            acc1 = c_in1_valid && c_in1_ready;
            @(posedge clk); #1;
            if (acc0) p0++;
            if (acc1) p1++;
        end
        checks++;
        if (oi != cycles - 1 - stall_len) begin
            errors++;
            $display("FAIL comb_count: got %0d beats expected %0d", oi, cycles - 1 - stall_len);
        end
    endtask

    task automatic test_comb_stream();
        p0 = 0; p1 = 0;
        comb_run(45, 1000, 0);
    endtask

    task automatic test_comb_stall();
        p0 = 0; p1 = 0;
        comb_run(50, 10, 5);
    endtask

    task automatic test_comb_reset_mid();
        p0 = 0; p1 = 0;
        comb_run(20, 1000, 0);
        checks++;
        if (c_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL comb_mid_valid: output_valid=%b expected 1 before reset", c_out_valid);
        end
        // Producers keep their values; the round must restart on port 0.
        comb_run(40, 1000, 0);
        c_in0_valid = 1'b0; c_in1_valid = 1'b0;
    endtask

    task automatic test_filter();
        logic [DW-1:0] exp_f1 [4];
        logic [DW-1:0] exp_f0 [4];
        int n1;
        int n0;
        int pairs;
        exp_f1 = '{39'd0, 39'd2, 39'd4, 39'd6};
        exp_f0 = '{39'd1, 39'd3, 39'd5, 39'd7};
        n1 = 0; n0 = 0; pairs = 0;
        f_out_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                f_in0_valid = 1'b1; f_in1_valid = 1'b1;
                f_in0_data  = DW'(i);
                f_in1_data  = {5'b10101, i[0]};
            end else begin
                f_in0_valid = 1'b0; f_in1_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 8) begin
                checks++;
                if ({f1_in0_ready, f1_in1_ready, f0_in0_ready, f0_in1_ready} !== 4'b1111) begin
                    errors++;
                    $display("FAIL filter_ready[%0d]: got %b expected 1111", i,
                             {f1_in0_ready, f1_in1_ready, f0_in0_ready, f0_in1_ready});
                end
                if (f1_in0_ready && f1_in1_ready) pairs++;
            end
            if (f1_out_valid === 1'b1) begin
                checks++;
                if ((n1 >= 4) || (f1_out_data !== exp_f1[n1])) begin
                    errors++;
                    $display("FAIL filter_up_data[%0d]: got %0h expected %0h", n1, f1_out_data, (n1 < 4) ? exp_f1[n1] : {DW{1'b1}});
                end
                n1++;
            end
            if (f0_out_valid === 1'b1) begin
                checks++;
                if ((n0 >= 4) || (f0_out_data !== exp_f0[n0])) begin
                    errors++;
                    $display("FAIL filter_down_data[%0d]: got %0h expected %0h", n0, f0_out_data, (n0 < 4) ? exp_f0[n0] : {DW{1'b1}});
                end
                n0++;
            end
            @(posedge clk); #1;
        end
        checks++;
        if ((n1 != 4) || (n0 != 4) || (pairs != 8)) begin
            errors++;
            $display("FAIL filter_counts: kept %0d/%0d pairs %0d expected 4/4 pairs 8", n1, n0, pairs);
        end
    endtask

    task automatic test_filter_idle();
        f_in0_valid = 1'b1; f_in1_valid = 1'b0;
        f_in0_data  = 39'h55; f_in1_data = 6'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({f1_in0_ready, f0_in0_ready, f1_out_valid, f0_out_valid} !== 4'b0000) begin
                errors++;
                $display("FAIL filter_idle[%0d]: in0_ready/valid=%b expected 0000", i,
                         {f1_in0_ready, f0_in0_ready, f1_out_valid, f0_out_valid});
            end
            @(posedge clk); #1;
        end
        f_in0_valid = 1'b0;
    endtask

    task automatic test_shifter();
        logic [DW-1:0] vec_d [6];
        logic [SW-1:0] vec_s [6];
        logic [DW-1:0] exp_l [6];
        logic [DW-1:0] exp_a [6];
        logic [DW-1:0] exp_r [6];
        vec_d = '{39'h3, 39'h3, 39'h40_0000_0000, 39'h40_0000_0001, 39'h12_3456_789A, 39'h7F_FFFF_FFF0};
        vec_s = '{6'd4, 6'd39, 6'd38, 6'd63, 6'd0, 6'd1};
        exp_l = '{39'h30, 39'h0, 39'h0, 39'h0, 39'h12_3456_789A, 39'h7F_FFFF_FFE0};
        exp_a = '{39'h0, 39'h0, 39'h7F_FFFF_FFFF, 39'h7F_FFFF_FFFF, 39'h12_3456_789A, 39'h7F_FFFF_FFF8};
        exp_r = '{39'h0, 39'h0, 39'h1, 39'h0, 39'h12_3456_789A, 39'h3F_FFFF_FFF8};
        s_out_ready = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) begin
                s_in0_valid = 1'b1; s_in1_valid = 1'b1;
                s_in0_data  = vec_d[i];
                s_in1_data  = vec_s[i];
            end else begin
                s_in0_valid = 1'b0; s_in1_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 6) begin
                checks++;
                if ({sl_in0_ready, sl_in1_ready, sa_in0_ready, sr_in1_ready} !== 4'b1111) begin
                    errors++;
                    $display("FAIL shift_ready[%0d]: got %b expected 1111", i,
                             {sl_in0_ready, sl_in1_ready, sa_in0_ready, sr_in1_ready});
                end
            end
            if (i > 0) begin
                checks++;
                if ((sl_out_valid !== 1'b1) || (sl_out_data !== exp_l[i-1])) begin
                    errors++;
                    $display("FAIL shift_left[%0d]: valid=%b data=%0h expected 1 %0h", i-1, sl_out_valid, sl_out_data, exp_l[i-1]);
                end
                checks++;
                if ((sa_out_valid !== 1'b1) || (sa_out_data !== exp_a[i-1])) begin
                    errors++;
                    $display("FAIL shift_arith[%0d]: valid=%b data=%0h expected 1 %0h", i-1, sa_out_valid, sa_out_data, exp_a[i-1]);
                end
                checks++;
                if ((sr_out_valid !== 1'b1) || (sr_out_data !== exp_r[i-1])) begin
                    errors++;
                    $display("FAIL shift_logic[%0d]: valid=%b data=%0h expected 1 %0h", i-1, sr_out_valid, sr_out_data, exp_r[i-1]);
                end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if ({sl_out_valid, sa_out_valid, sr_out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL shift_drain: valid=%b expected 000", {sl_out_valid, sa_out_valid, sr_out_valid});
        end
    endtask

    initial begin
        test_reset();
        test_comb_stream();
        test_comb_stall();
        test_comb_reset_mid();
        test_filter();
        test_filter_idle();
        test_shifter();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
